alu_issue: RTL and testbench

- Execute-stage issue unit: the producer side of the ALU operand/opcode interface.
- Takes a fetched RV32 instruction plus register-file read values and PC, and decodes it into alu_op (codes from cpu/aluops.vh), op_a, op_b and sideband fields.
- Presents the result as a registered, valid/ready beat to the ALU stage.
- Contains a 2-entry skid buffer so upstream ready is fully registered.

---
 rtl/alu_issue.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_alu_issue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32 execute-stage issue unit: decodes an instruction into ALU opcode/operands and
// presents it through a 2-entry skid buffer. Define RV32M_EN to decode the M-extension ops.

`ifndef ALUOPS_VH
`define ALUOPS_VH
`define ADD     5'd0
`define SUB     5'd1
`define SUBU    5'd2
`define AND     5'd3
`define OR      5'd4
`define XOR     5'd5
`define LSHIFT  5'd6
`define LRSHIFT 5'd7
`define ARSHIFT 5'd8
`define MUL     5'd9
`define DIV     5'd10
`define DIVU    5'd11
`define REM     5'd12
`define REMU    5'd13
`endif

module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            is_cmp,
  output logic            illegal_instr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            is_cmp;
    logic            illegal;
  } beat_t;

  state_t r_state;
  state_t w_state_nxt;
  beat_t  r_out;
  beat_t  r_skid;
  beat_t  w_dec;
  logic   r_out_valid;
  logic   r_in_ready;
  logic   w_accept;
  logic   w_drain;
  logic   w_load_out_in;
  logic   w_load_out_skid;
  logic   w_load_skid;
  logic   w_ill;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_u  = {instr[31:12], 12'h000};
  assign w_shamt  = {27'd0, instr[24:20]};

  // Instruction decode into a candidate beat
  always_comb begin
    w_dec        = '0;
    w_dec.alu_op = `ADD;
    w_dec.rd     = instr[11:7];
    w_dec.funct3 = w_f3;
    w_ill        = 1'b0;
    if (instr[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      case (w_opcode)
        7'b0110011: begin
          w_dec.op_a = rs1_val;
          w_dec.op_b = rs2_val;
          case (w_f7)
            7'b0000000: begin
              case (w_f3)
                3'b000:  w_dec.alu_op = `ADD;
                3'b001:  w_dec.alu_op = `LSHIFT;
                3'b010:  begin w_dec.alu_op = `SUB;  w_dec.is_cmp = 1'b1; end
                3'b011:  begin w_dec.alu_op = `SUBU; w_dec.is_cmp = 1'b1; end
                3'b100:  w_dec.alu_op = `XOR;
                3'b101:  w_dec.alu_op = `LRSHIFT;
                3'b110:  w_dec.alu_op = `OR;
                3'b111:  w_dec.alu_op = `AND;
                default: w_ill = 1'b1;
              endcase
            end
            7'b0100000: begin
              case (w_f3)
                3'b000:  w_dec.alu_op = `SUB;
                3'b101:  w_dec.alu_op = `ARSHIFT;
                default: w_ill = 1'b1;
              endcase
            end
`ifdef RV32M_EN
            7'b0000001: begin
              case (w_f3)
                3'b000:  w_dec.alu_op = `MUL;
                3'b100:  w_dec.alu_op = `DIV;
                3'b101:  w_dec.alu_op = `DIVU;
                3'b110:  w_dec.alu_op = `REM;
                3'b111:  w_dec.alu_op = `REMU;
                default: w_ill = 1'b1;
              endcase
            end
`endif
            default: w_ill = 1'b1;
          endcase
        end
        7'b0010011: begin
          w_dec.op_a = rs1_val;
          w_dec.op_b = w_imm_i;
          case (w_f3)
            3'b000: w_dec.alu_op = `ADD;
            3'b001: begin
              w_dec.alu_op = `LSHIFT;
              w_dec.op_b   = w_shamt;
              if (w_f7 != 7'b0000000) begin
                w_ill = 1'b1;
              end else begin
                w_ill = 1'b0;
              end
            end
            3'b010: begin w_dec.alu_op = `SUB;  w_dec.is_cmp = 1'b1; end
            3'b011: begin w_dec.alu_op = `SUBU; w_dec.is_cmp = 1'b1; end
            3'b100: w_dec.alu_op = `XOR;
            3'b101: begin
              w_dec.op_b = w_shamt;
              if (w_f7 == 7'b0000000) begin
                w_dec.alu_op = `LRSHIFT;
              end else if (w_f7 == 7'b0100000) begin
                w_dec.alu_op = `ARSHIFT;
              end else begin
                w_ill = 1'b1;
              end
            end
            3'b110:  w_dec.alu_op = `OR;
            3'b111:  w_dec.alu_op = `AND;
            default: w_ill = 1'b1;
          endcase
        end
        7'b0110111: w_dec.op_b = w_imm_u;
        7'b0010111: begin w_dec.op_a = pc; w_dec.op_b = w_imm_u; end
        7'b0000011: begin w_dec.op_a = rs1_val; w_dec.op_b = w_imm_i; end
        7'b0100011: begin
          w_dec.op_a = rs1_val;
          w_dec.op_b = w_imm_s;
          w_dec.rd   = 5'd0;
        end
        7'b1100011: begin
          w_dec.op_a   = rs1_val;
          w_dec.op_b   = rs2_val;
          w_dec.rd     = 5'd0;
          w_dec.is_cmp = 1'b1;
          if (w_f3 == 3'b110 || w_f3 == 3'b111) begin
            w_dec.alu_op = `SUBU;
          end else begin
            w_dec.alu_op = `SUB;
          end
        end
        7'b1101111, 7'b1100111: begin
          w_dec.op_a = pc;
          w_dec.op_b = 32'd4;
        end
        default: w_ill = 1'b1;
      endcase
    end
    // Illegal beats still flow in order but carry a neutral payload
    if (w_ill) begin
      w_dec.alu_op  = `ADD;
      w_dec.op_a    = '0;
      w_dec.op_b    = '0;
      w_dec.rd      = 5'd0;
      w_dec.is_cmp  = 1'b0;
      w_dec.illegal = 1'b1;
    end else begin
      w_dec.illegal = 1'b0;
    end
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_out_valid && out_ready;

  // Skid-buffer next state and slot load controls
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt   = ST_ONE;
            w_load_out_in = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_out_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_state_nxt     = ST_ONE;
            w_load_out_skid = 1'b1;
          end else begin
            w_state_nxt = ST_TWO;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and beat slots
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_TWO);
      if (w_load_out_in) begin
        r_out <= w_dec;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end else begin
        r_out <= r_out;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end else begin
        r_skid <= r_skid;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign alu_op        = r_out.alu_op;
  assign op_a          = r_out.op_a;
  assign op_b          = r_out.op_b;
  assign rd            = r_out.rd;
  assign funct3        = r_out.funct3;
  assign is_cmp        = r_out.is_cmp;
  assign illegal_instr = r_out.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, back-to-back issue,
// stall/skid behaviour, flush and reset.
module tb_alu_issue;

  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_SUBU    = 5'd2;
  localparam logic [4:0] ALU_ARSHIFT = 5'd8;
  localparam logic [4:0] ALU_MUL     = 5'd9;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_val, rs2_val, op_a, op_b;
  logic [4:0]  alu_op, rd;
  logic [2:0]  funct3;
  logic        is_cmp, illegal_instr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] instr, pc, rs1, rs2;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        cmp, ill;
  } vec_t;

  vec_t vecs[9];

  alu_issue #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .rd(rd),
    .funct3(funct3), .is_cmp(is_cmp), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b);
    instr    = i;
    pc       = p;
    rs1_val  = a;
    rs2_val  = b;
    in_valid = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic ill);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".op"}, {27'd0, alu_op}, {27'd0, op});
    chk({tag, ".a"}, op_a, a);
    chk({tag, ".b"}, op_b, b);
    chk({tag, ".rd"}, {27'd0, rd}, {27'd0, r});
    chk({tag, ".ill"}, {31'd0, illegal_instr}, {31'd0, ill});
  endtask

  initial begin
    vecs[0] = '{"sub",     32'h40208033, 32'h0,   32'd7,     32'd9,  ALU_SUB,  32'd7,     32'd9,        5'd0,  3'd0, 1'b0, 1'b0};
    vecs[1] = '{"jal",     32'h008000EF, 32'h100, 32'h0,     32'h0,  ALU_ADD,  32'h100,   32'd4,        5'd1,  3'd0, 1'b0, 1'b0};
    vecs[2] = '{"auipc",   32'h00001517, 32'h200, 32'h0,     32'h0,  ALU_ADD,  32'h200,   32'h1000,     5'd10, 3'd1, 1'b0, 1'b0};
    vecs[3] = '{"bltu",    32'h0020E463, 32'h0,   32'd3,     32'd5,  ALU_SUBU, 32'd3,     32'd5,        5'd0,  3'd6, 1'b1, 1'b0};
    vecs[4] = '{"sw_neg",  32'hFE20AE23, 32'h0,   32'h1000,  32'h55, ALU_ADD,  32'h1000,  32'hFFFFFFFC, 5'd0,  3'd2, 1'b0, 1'b0};
    vecs[5] = '{"sltiu",   32'h0010B213, 32'h0,   32'h20,    32'h0,  ALU_SUBU, 32'h20,    32'd1,        5'd4,  3'd3, 1'b1, 1'b0};
    vecs[6] = '{"bad_sll", 32'h40309093, 32'h0,   32'h11,    32'h0,  ALU_ADD,  32'h0,     32'h0,        5'd0,  3'd1, 1'b0, 1'b1};
    vecs[7] = '{"bad_lsb", 32'h40208030, 32'h0,   32'h11,    32'h22, ALU_ADD,  32'h0,     32'h0,        5'd0,  3'd0, 1'b0, 1'b1};
`ifdef RV32M_EN
    vecs[8] = '{"mul",     32'h022081B3, 32'h0,   32'd6,     32'd7,  ALU_MUL,  32'd6,     32'd7,        5'd3,  3'd0, 1'b0, 1'b0};
`else
    vecs[8] = '{"mul",     32'h022081B3, 32'h0,   32'd6,     32'd7,  ALU_ADD,  32'h0,     32'h0,        5'd0,  3'd0, 1'b0, 1'b1};
`endif

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
    step();
    step();
    rst = 1'b0;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd1);
    chk("rst.op", {27'd0, alu_op}, 32'd0);
    chk("rst.a", op_a, 32'd0);
    chk("rst.b", op_b, 32'd0);
    chk("rst.rd", {27'd0, rd}, 32'd0);
    chk("rst.f3", {29'd0, funct3}, 32'd0);
    chk("rst.cmp", {31'd0, is_cmp}, 32'd0);
    chk("rst.ill", {31'd0, illegal_instr}, 32'd0);

    // Single-beat decode vectors, each drained the following cycle
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      step();
      in_valid = 1'b0;
      chk_beat(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].ill);
      chk({vecs[i].tag, ".f3"}, {29'd0, funct3}, {29'd0, vecs[i].f3});
      chk({vecs[i].tag, ".cmp"}, {31'd0, is_cmp}, {31'd0, vecs[i].cmp});
      step();
      chk({vecs[i].tag, ".drained"}, {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back addi / srai
    drive(32'hFFF00293, 32'h0, 32'h0, 32'h0);
    step();
    drive(32'h4030D093, 32'h0, 32'h80000000, 32'h0);
    chk_beat("addi", ALU_ADD, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b0);
    step();
    in_valid = 1'b0;
    chk_beat("srai", ALU_ARSHIFT, 32'h80000000, 32'd3, 5'd1, 1'b0);
    step();
    chk("b2b.drained", {31'd0, out_valid}, 32'd0);

    // Stall with three beats offered, then drain in order
    out_ready = 1'b0;
    drive(32'h123450B7, 32'h0, 32'h0, 32'h0);
    step();
    chk("stall1.ready", {31'd0, in_ready}, 32'd1);
    chk_beat("stall1", ALU_ADD, 32'h0, 32'h12345000, 5'd1, 1'b0);
    drive(32'hFFF00293, 32'h0, 32'h0, 32'h0);
    step();
    chk("stall2.ready", {31'd0, in_ready}, 32'd0);
    chk_beat("stall2", ALU_ADD, 32'h0, 32'h12345000, 5'd1, 1'b0);
    drive(32'h40208033, 32'h0, 32'd7, 32'd9);
    step();
    chk("stall3.ready", {31'd0, in_ready}, 32'd0);
    chk_beat("stall3", ALU_ADD, 32'h0, 32'h12345000, 5'd1, 1'b0);
    out_ready = 1'b1;
    step();
    chk("ord2.ready", {31'd0, in_ready}, 32'd1);
    chk_beat("ord2", ALU_ADD, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b0);
    step();
    in_valid = 1'b0;
    chk_beat("ord3", ALU_SUB, 32'd7, 32'd9, 5'd0, 1'b0);
    step();
    chk("ord.drained", {31'd0, out_valid}, 32'd0);

    // Flush from ONE with a beat offered in the flush cycle
    out_ready = 1'b0;
    drive(32'hFFF00293, 32'h0, 32'h0, 32'h0);
    step();
    drive(32'h4030D093, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1.valid", {31'd0, out_valid}, 32'd0);
    chk("fl1.ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("fl1.gone", {31'd0, out_valid}, 32'd0);

    // Flush from TWO
    out_ready = 1'b0;
    drive(32'hFFF00293, 32'h0, 32'h0, 32'h0);
    step();
    drive(32'h4030D093, 32'h0, 32'h0, 32'h0);
    step();
    chk("fl2.full", {31'd0, in_ready}, 32'd0);
    drive(32'h123450B7, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2.valid", {31'd0, out_valid}, 32'd0);
    chk("fl2.ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl2.gone", {31'd0, out_valid}, 32'd0);
    end

    // Illegal all-zero instruction, then reset while it is pending
    out_ready = 1'b0;
    drive(32'h00000000, 32'h0, 32'h33, 32'h44);
    step();
    chk_beat("zero", ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
    drive(32'h40208033, 32'h0, 32'd7, 32'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst2.valid", {31'd0, out_valid}, 32'd0);
    chk("rst2.ready", {31'd0, in_ready}, 32'd1);
    chk("rst2.op", {27'd0, alu_op}, 32'd0);
    chk("rst2.b", op_b, 32'd0);
    chk("rst2.ill", {31'd0, illegal_instr}, 32'd0);
    step();
    chk("rst2.idle", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
